sdram_refresh: RTL

- Periodic AUTO REFRESH engine sitting directly downstream of sdram_initialize.
- Stays idle until the init block's ofin is seen.
- Then counts refresh intervals, accumulates refresh debt, requests the SDRAM command bus from the arbiter, and issues PRECHARGE ALL followed by one AUTO REFRESH per owed interval.
- Its DRAM_* outputs feed the same command-bus mux as sdram_initialize.

---
 rtl/sdram_refresh.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sdram_refresh.sv
// Periodic AUTO REFRESH engine: tracks refresh debt, arbitrates for the SDRAM command bus and
// issues PRECHARGE ALL + AUTO REFRESH bursts. Optional stats ports under SDRAM_REFRESH_STATS_EN.
module sdram_refresh #(
  parameter int REFRESH_INTERVAL = 390,
  parameter int TRP              = 2,
  parameter int TRFC             = 7,
  parameter int MAX_DEBT         = 8,
  parameter int URGENT_THRESH    = 4
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        iinit_done,
  input  logic        igrant,
  output logic        oreq,
  output logic        ourgent,
  output logic        obusy,
  output logic        ofin,
  output logic        ooverflow,
  output logic        DRAM_CKE,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_LDQM,
  output logic        DRAM_UDQM
`ifdef SDRAM_REFRESH_STATS_EN
  ,
  output logic [15:0] ostat_refreshes,
  output logic [3:0]  ostat_max_debt
`endif
);

  localparam int CNT_W     = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int DEBT_W    = $clog2(MAX_DEBT + 1);
  localparam int WAIT_MAX  = (TRP > TRFC) ? TRP : TRFC;
  localparam int WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam int TRP_LOAD  = (TRP > 1) ? TRP - 2 : 0;
  localparam int TRFC_LOAD = (TRFC > 1) ? TRFC - 2 : 0;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [2:0] {
    WAIT_INIT, IDLE, REQ, PRE, TRP_WAIT, REF, TRFC_WAIT, DONE
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    int_cnt;
  logic [DEBT_W-1:0]   debt;
  logic [DEBT_W-1:0]   debt_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                expiry;
  logic                refresh_dec;
  logic [3:0]          cmd_next;

  // Bus handshake: oreq is held from REQ entry until igrant is sampled high; the bus is then
  // owned from PRE through the last refresh wait, and igrant is not looked at again until DONE.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_INIT: if (iinit_done) next_state = IDLE;
      IDLE:      if (debt != '0) next_state = REQ;
      REQ:       if (igrant) next_state = PRE;
      PRE:       next_state = (TRP > 1) ? TRP_WAIT : REF;
      TRP_WAIT:  if (wait_cnt == '0) next_state = REF;
      REF: begin
        if (TRFC > 1)          next_state = TRFC_WAIT;
        else if (debt != '0)   next_state = REF;
        else                   next_state = DONE;
      end
      TRFC_WAIT: if (wait_cnt == '0) next_state = (debt != '0) ? REF : DONE;
      DONE:      next_state = IDLE;
      default:   next_state = WAIT_INIT;
    endcase
  end

  // Debt is charged by interval expiry and paid on entry to REF; both together cancel out.
  always_comb begin
    expiry      = (state != WAIT_INIT) && (int_cnt == '0);
    refresh_dec = (next_state == REF);
    debt_next   = debt;
    if (expiry && !refresh_dec) begin
      if (debt != DEBT_W'(MAX_DEBT)) debt_next = debt + DEBT_W'(1);
    end else if (refresh_dec && !expiry) begin
      debt_next = debt - DEBT_W'(1);
    end
  end

  always_comb begin
    cmd_next = CMD_NOP;
    if (next_state == PRE)      cmd_next = CMD_PRE;
    else if (next_state == REF) cmd_next = CMD_REF;
  end

  assign ourgent = (state != WAIT_INIT) && (debt >= DEBT_W'(URGENT_THRESH));

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state      <= WAIT_INIT;
      int_cnt    <= CNT_W'(REFRESH_INTERVAL - 1);
      debt       <= '0;
      wait_cnt   <= '0;
      ooverflow  <= 1'b0;
      oreq       <= 1'b0;
      obusy      <= 1'b0;
      ofin       <= 1'b0;
      DRAM_CKE   <= 1'b0;
      DRAM_ADDR  <= '0;
      DRAM_BA    <= '0;
      {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= CMD_NOP;
      DRAM_LDQM  <= 1'b1;
      DRAM_UDQM  <= 1'b1;
    end else begin
      state <= next_state;
      if (state != WAIT_INIT)
        int_cnt <= (int_cnt == '0) ? CNT_W'(REFRESH_INTERVAL - 1) : int_cnt - CNT_W'(1);
      debt <= debt_next;
      if (expiry && debt == DEBT_W'(MAX_DEBT)) ooverflow <= 1'b1;

      if (next_state == TRP_WAIT && state != TRP_WAIT)
        wait_cnt <= WAIT_W'(TRP_LOAD);
      else if (next_state == TRFC_WAIT && state != TRFC_WAIT)
        wait_cnt <= WAIT_W'(TRFC_LOAD);
      else if (wait_cnt != '0)
        wait_cnt <= wait_cnt - WAIT_W'(1);

      // Outputs are registered from next_state so they line up with the state register.
      oreq      <= (next_state == REQ);
      obusy     <= (next_state == PRE) || (next_state == TRP_WAIT) ||
                   (next_state == REF) || (next_state == TRFC_WAIT);
      ofin      <= (next_state == DONE);
      DRAM_CKE  <= (next_state != WAIT_INIT);
      DRAM_ADDR <= (next_state == PRE) ? 13'h0400 : 13'h0000;
      DRAM_BA   <= '0;
      {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} <= cmd_next;
      DRAM_LDQM <= 1'b1;
      DRAM_UDQM <= 1'b1;
    end
  end

`ifdef SDRAM_REFRESH_STATS_EN
  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      ostat_refreshes <= '0;
      ostat_max_debt  <= '0;
    end else begin
      if (refresh_dec) ostat_refreshes <= ostat_refreshes + 16'd1;
      if (4'(debt_next) > ostat_max_debt) ostat_max_debt <= 4'(debt_next);
    end
  end
`endif

endmodule
